// File: rtl/keypad_pkg.sv
// Shared types and constants for the keypad responder: FSM states, key codes,
// the four one-hot-low column patterns and the scan counter width.
package keypad_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PRESS   = 2'd1,
    ST_RELEASE = 2'd2
  } state_e;

  // [3:2] row index, [1:0] column index
  typedef logic [3:0] key_code_t;

  localparam logic [3:0] COL_0    = 4'b0111;
  localparam logic [3:0] COL_1    = 4'b1011;
  localparam logic [3:0] COL_2    = 4'b1101;
  localparam logic [3:0] COL_3    = 4'b1110;
  localparam logic [3:0] COL_NONE = 4'b1111;

  localparam int SCAN_CNT_W = 8;

endpackage

// File: rtl/key_fifo.sv
// Key-code queue. A push into a full queue is dropped even when a pop happens
// in the same cycle, so key_ready can be a plain function of the count.
module key_fifo
  import keypad_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      push_i,
  input  key_code_t data_i,
  input  logic      pop_i,
  output key_code_t data_o,
  output logic      full_o,
  output logic      empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

  key_code_t     mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [AW:0]   count_q;
  logic          do_push;
  logic          do_pop;

  assign full_o  = (count_q == FULL_CNT);
  assign empty_o = (count_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign data_o  = mem_q[rd_ptr_q];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage needs no reset: it is only read when count_q says it holds data.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/keypad_responder.sv
// Keypad end of a column-scan protocol: replays queued key codes as presses
// held for HOLD_SCANS scans, separated by GAP_SCANS scans of release.
//
// state      | meaning
// ST_IDLE    | no key held; pops the next queued code when one is present
// ST_PRESS   | key held; counts scans up to HOLD_SCANS
// ST_RELEASE | key released; counts scans up to GAP_SCANS before the next key
module keypad_responder
  import keypad_pkg::*;
#(
  parameter int HOLD_SCANS = 8,
  parameter int GAP_SCANS  = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       key_valid,
  input  logic [3:0] key_code,
  output logic       key_ready,
  input  logic [3:0] kpc,
  output logic [3:0] kpr,
  output logic       pressed,
  output logic       busy
);

  localparam logic [SCAN_CNT_W-1:0] HOLD_TC = HOLD_SCANS[SCAN_CNT_W-1:0];
  localparam logic [SCAN_CNT_W-1:0] GAP_TC  = GAP_SCANS[SCAN_CNT_W-1:0];

  state_e                state_q;
  key_code_t             key_q;
  key_code_t             fifo_head;
  logic [SCAN_CNT_W-1:0] cnt_q;
  logic [SCAN_CNT_W-1:0] cnt_inc;
  logic [3:0]            kpc_q;
  logic                  pressed_q;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic                  fifo_pop;
  logic                  scan_evt;

  // A scan is the entry into column 0; a scanner stalled on column 0 counts once.
  assign scan_evt = (kpc == COL_0) && (kpc_q != COL_0);
  assign fifo_pop = (state_q == ST_IDLE) && !fifo_empty;
  assign cnt_inc  = cnt_q + 1'b1;

  key_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (reset_n),
    .push_i  (key_valid),
    .data_i  (key_code),
    .pop_i   (fifo_pop),
    .data_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      key_q     <= '0;
      cnt_q     <= '0;
      kpc_q     <= COL_NONE;
      pressed_q <= 1'b0;
    end else begin
      kpc_q <= kpc;
      case (state_q)
        ST_IDLE: begin
          if (!fifo_empty) begin
            key_q     <= fifo_head;
            cnt_q     <= '0;
            state_q   <= ST_PRESS;
            pressed_q <= 1'b1;
          end
        end
        ST_PRESS: begin
          if (scan_evt) begin
            if (cnt_inc == HOLD_TC) begin
              cnt_q     <= '0;
              state_q   <= ST_RELEASE;
              pressed_q <= 1'b0;
            end else begin
              cnt_q <= cnt_inc;
            end
          end
        end
        ST_RELEASE: begin
          if (scan_evt) begin
            if (cnt_inc == GAP_TC) begin
              cnt_q   <= '0;
              state_q <= ST_IDLE;
            end else begin
              cnt_q <= cnt_inc;
            end
          end
        end
        default: begin
          state_q   <= ST_IDLE;
          pressed_q <= 1'b0;
        end
      endcase
    end
  end

  // Row drive follows kpc combinationally so the scanner sees it in the same column slot.
  always_comb begin
    kpr = COL_NONE;
    if (pressed_q && !kpc[key_q[1:0]]) kpr[key_q[3:2]] = 1'b0;
  end

  assign pressed   = pressed_q;
  assign busy      = !fifo_empty || (state_q != ST_IDLE);
  assign key_ready = !fifo_full;

endmodule

// File: tb/tb_keypad_responder.sv
// Bench for keypad_responder: directed tests and a random run, all checked
// against a queue-and-countdown model of the key replay behaviour.
module tb_keypad_responder;

  localparam int HOLD  = 2;
  localparam int GAP   = 4;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       key_valid;
  logic [3:0] key_code;
  logic       key_ready;
  logic [3:0] kpc;
  logic [3:0] kpr;
  logic       pressed;
  logic       busy;

  keypad_responder #(.HOLD_SCANS(HOLD), .GAP_SCANS(GAP), .FIFO_DEPTH(DEPTH)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .key_valid (key_valid),
    .key_code  (key_code),
    .key_ready (key_ready),
    .kpc       (kpc),
    .kpr       (kpr),
    .pressed   (pressed),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Model: pending codes, held key, phase (0 idle, 1 held, 2 gap), scans left.
  logic [3:0] mq[$];
  logic [3:0] m_cur;
  logic [3:0] m_prev;
  int         m_phase;
  int         m_left;

  logic [3:0] log_q[$];
  bit         logged;
  logic [3:0] obs_kpr;
  logic       obs_pressed, obs_busy, obs_ready;
  logic [3:0] scan_seq [4] = '{4'b1011, 4'b1101, 4'b1110, 4'b0111};

  typedef struct {
    logic [3:0] kpc;
    logic [3:0] kpr;
    logic       pressed;
  } vec_t;
  vec_t tbl [9];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_cur   = 4'h0;
    m_prev  = 4'b1111;
    m_phase = 0;
    m_left  = 0;
  endtask

  function automatic logic [3:0] model_kpr(input logic [3:0] k);
    logic [3:0] r = 4'b1111;
    if (m_phase == 1 && k[m_cur[1:0]] == 1'b0) r[m_cur[3:2]] = 1'b0;
    return r;
  endfunction

  task automatic model_step(input logic v, input logic [3:0] code, input logic [3:0] k);
    bit scan = (k == 4'b0111) && (m_prev != 4'b0111);
    bit room = mq.size() < DEPTH;
    if (m_phase == 0) begin
      if (mq.size() > 0) begin
        m_cur   = mq.pop_front();
        m_phase = 1;
        m_left  = HOLD;
      end
    end else if (scan) begin
      m_left--;
      if (m_left == 0) begin
        if (m_phase == 1) begin
          m_phase = 2;
          m_left  = GAP;
        end else begin
          m_phase = 0;
        end
      end
    end
    if (v && room) mq.push_back(code);
    m_prev = k;
  endtask

  // Records each press once, decoded from the row pulled low and the active column.
  task automatic monitor(input logic [3:0] k);
    int row = -1, col = -1, zeros = 0;
    if (!obs_pressed) begin
      logged = 0;
      return;
    end
    if (logged || obs_kpr == 4'b1111) return;
    for (int i = 0; i < 4; i++) begin
      if (!obs_kpr[i]) row = i;
      if (!k[i]) begin col = i; zeros++; end
    end
    if (zeros == 1 && row >= 0) begin
      log_q.push_back(4'(row * 4 + col));
      logged = 1;
    end
  endtask

  task automatic cycle(input logic v, input logic [3:0] code, input logic [3:0] k);
    @(negedge clk);
    key_valid = v;
    key_code  = code;
    kpc       = k;
    #1;
    obs_kpr = kpr; obs_pressed = pressed; obs_busy = busy; obs_ready = key_ready;
    chk("model_kpr", obs_kpr, model_kpr(k));
    chk("model_pressed", obs_pressed, m_phase == 1);
    chk("model_busy", obs_busy, (mq.size() != 0) || (m_phase != 0));
    chk("model_key_ready", obs_ready, mq.size() < DEPTH);
    monitor(k);
    @(posedge clk);
    model_step(v, code, k);
  endtask

  task automatic scans(input int n);
    for (int s = 0; s < n; s++)
      for (int c = 0; c < 4; c++) cycle(1'b0, 4'h0, scan_seq[c]);
  endtask

  initial begin
    int low_cnt, bad_rows, rel_cnt, pr_cnt, idx;
    logic [3:0] k;

    tbl[0] = '{4'b0000, 4'b1011, 1'b1};
    tbl[1] = '{4'b1111, 4'b1111, 1'b1};
    tbl[2] = '{4'b0111, 4'b1011, 1'b1};
    tbl[3] = '{4'b1011, 4'b1111, 1'b1};
    tbl[4] = '{4'b1101, 4'b1111, 1'b1};
    tbl[5] = '{4'b1110, 4'b1111, 1'b1};
    tbl[6] = '{4'b1000, 4'b1111, 1'b1};
    tbl[7] = '{4'b0110, 4'b1011, 1'b1};
    tbl[8] = '{4'b0000, 4'b1011, 1'b1};

    reset_n = 1'b0; key_valid = 1'b0; key_code = 4'h0; kpc = 4'b1111;
    model_reset();
    #2;
    chk("reset_kpr", kpr, 4'b1111);
    chk("reset_pressed", pressed, 1'b0);
    chk("reset_busy", busy, 1'b0);
    chk("reset_key_ready", key_ready, 1'b1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;

    // Single key 0110 held two scans, then four scans of release.
    logged = 0; log_q.delete();
    cycle(1'b1, 4'b0110, 4'b1111);
    cycle(1'b0, 4'h0, 4'b1111);
    low_cnt = 0; bad_rows = 0;
    for (int s = 0; s < 8; s++)
      for (int c = 0; c < 4; c++) begin
        cycle(1'b0, 4'h0, scan_seq[c]);
        if (obs_kpr == 4'b1101 && scan_seq[c] == 4'b1011) low_cnt++;
        else if (obs_kpr != 4'b1111) bad_rows++;
      end
    chk("single_low_cycles", low_cnt, 2);
    chk("single_stray_rows", bad_rows, 0);
    cycle(1'b0, 4'h0, 4'b1111);
    chk("single_busy_done", obs_busy, 1'b0);
    chk("single_log_len", log_q.size(), 1);
    if (log_q.size() >= 1) chk("single_log_code", log_q[0], 4'b0110);

    // Back-to-back pushes: simultaneous push/pop, then fill and reject.
    logged = 0; log_q.delete();
    cycle(1'b1, 4'd0, 4'b1111);
    cycle(1'b1, 4'd1, 4'b1111);
    cycle(1'b1, 4'd2, 4'b1111);
    cycle(1'b1, 4'd3, 4'b1111);
    cycle(1'b1, 4'd4, 4'b1111);
    chk("fill_ready_before_full", obs_ready, 1'b1);
    cycle(1'b1, 4'd5, 4'b1111);
    chk("fill_ready_when_full", obs_ready, 1'b0);
    chk("fill_pressed", obs_pressed, 1'b1);
    scans(40);
    chk("fill_log_len", log_q.size(), 5);
    for (int i = 0; i < 5; i++)
      if (i < log_q.size()) chk("fill_order", log_q[i], i);
    chk("fill_busy_done", obs_busy, 1'b0);

    // Scanner stalled on column 0 counts a single scan.
    cycle(1'b1, 4'b1001, 4'b1111);
    cycle(1'b0, 4'h0, 4'b1111);
    rel_cnt = 0;
    for (int i = 0; i < 100; i++) begin
      cycle(1'b0, 4'h0, 4'b0111);
      if (!obs_pressed) rel_cnt++;
    end
    chk("stall_release_cycles", rel_cnt, 0);
    cycle(1'b0, 4'h0, 4'b1111);
    cycle(1'b0, 4'h0, 4'b0111);
    cycle(1'b0, 4'h0, 4'b1111);
    chk("stall_second_scan_releases", obs_pressed, 1'b0);
    scans(6);
    chk("stall_busy_done", obs_busy, 1'b0);

    // Non-one-hot column patterns while key 1011 is held.
    cycle(1'b1, 4'b1011, 4'b1111);
    cycle(1'b0, 4'h0, 4'b1111);
    foreach (tbl[i]) begin
      cycle(1'b0, 4'h0, tbl[i].kpc);
      chk("table_kpr", obs_kpr, tbl[i].kpr);
      chk("table_pressed", obs_pressed, tbl[i].pressed);
    end
    scans(6);
    chk("table_busy_done", obs_busy, 1'b0);

    // Reset while a key is held with three codes queued.
    cycle(1'b1, 4'h3, 4'b1111);
    cycle(1'b1, 4'h7, 4'b1111);
    cycle(1'b1, 4'hB, 4'b1111);
    cycle(1'b1, 4'hF, 4'b1111);
    @(negedge clk);
    key_valid = 1'b0;
    kpc = 4'b0111;
    #1;
    chk("midreset_kpr_before", kpr, 4'b1110);
    reset_n = 1'b0;
    #1;
    chk("midreset_kpr", kpr, 4'b1111);
    chk("midreset_pressed", pressed, 1'b0);
    chk("midreset_busy", busy, 1'b0);
    chk("midreset_key_ready", key_ready, 1'b1);
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    kpc = 4'b1111;
    reset_n = 1'b1;
    pr_cnt = 0;
    for (int s = 0; s < 10; s++)
      for (int c = 0; c < 4; c++) begin
        cycle(1'b0, 4'h0, scan_seq[c]);
        if (obs_pressed) pr_cnt++;
      end
    chk("midreset_no_presses", pr_cnt, 0);
    chk("midreset_busy_after", obs_busy, 1'b0);

    // Random pushes and column patterns against the model.
    idx = 0;
    for (int i = 0; i < 1200; i++) begin
      if ($urandom_range(0, 5) == 0) k = 4'($urandom);
      else begin
        k = scan_seq[idx % 4];
        idx++;
      end
      cycle(($urandom_range(0, 3) == 0), 4'($urandom), k);
    end
    for (int i = 0; i < 80; i++) begin
      if (mq.size() == 0 && m_phase == 0) break;
      scans(1);
    end
    cycle(1'b0, 4'h0, 4'b1111);
    chk("random_drained", obs_busy, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
